// File: rtl/alu_iter_hs.sv
// alu_iter_hs: parametrised ALU with a valid/ready input handshake and registered result/error.
// Define ALU_ITER_DIV_EN to build the iterative restoring divider for opcode 0011.
module alu_iter_hs #(
  parameter int D_WIDTH   = 8,
  parameter int FUN_WIDTH = 4
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic [D_WIDTH-1:0]     A,
  input  logic [D_WIDTH-1:0]     B,
  input  logic [FUN_WIDTH-1:0]   ALU_FUN,
  input  logic                   IN_VALID,
  output logic                   IN_READY,
  output logic                   OUT_VALID,
  output logic [2*D_WIDTH-1:0]   ALU_OUT,
  output logic                   OUT_ERR
);
  localparam int W2 = 2 * D_WIDTH;

  localparam logic [FUN_WIDTH-1:0] OP_ADD  = FUN_WIDTH'(0);
  localparam logic [FUN_WIDTH-1:0] OP_SUB  = FUN_WIDTH'(1);
  localparam logic [FUN_WIDTH-1:0] OP_MUL  = FUN_WIDTH'(2);
  localparam logic [FUN_WIDTH-1:0] OP_AND  = FUN_WIDTH'(4);
  localparam logic [FUN_WIDTH-1:0] OP_OR   = FUN_WIDTH'(5);
  localparam logic [FUN_WIDTH-1:0] OP_NAND = FUN_WIDTH'(6);
  localparam logic [FUN_WIDTH-1:0] OP_NOR  = FUN_WIDTH'(7);
  localparam logic [FUN_WIDTH-1:0] OP_XOR  = FUN_WIDTH'(8);
  localparam logic [FUN_WIDTH-1:0] OP_XNOR = FUN_WIDTH'(9);
  localparam logic [FUN_WIDTH-1:0] OP_EQ   = FUN_WIDTH'(10);
  localparam logic [FUN_WIDTH-1:0] OP_GT   = FUN_WIDTH'(11);
  localparam logic [FUN_WIDTH-1:0] OP_LT   = FUN_WIDTH'(12);
  localparam logic [FUN_WIDTH-1:0] OP_SHR  = FUN_WIDTH'(13);
  localparam logic [FUN_WIDTH-1:0] OP_SHL  = FUN_WIDTH'(14);
`ifdef ALU_ITER_DIV_EN
  localparam logic [FUN_WIDTH-1:0] OP_DIV  = FUN_WIDTH'(3);
`endif

  // Single-cycle result: {error, 2W-bit zero-extended result}.
  function automatic logic [W2:0] f_alu(input logic [D_WIDTH-1:0] a, input logic [D_WIDTH-1:0] b,
                                        input logic [FUN_WIDTH-1:0] fun);
    logic [W2-1:0] a_x, b_x, res;
    logic          err;
    a_x = {{D_WIDTH{1'b0}}, a};
    b_x = {{D_WIDTH{1'b0}}, b};
    res = '0;
    err = 1'b0;
    case (fun)
      OP_ADD:  res = a_x + b_x;
      OP_SUB:  res = a_x - b_x;
      OP_MUL:  res = a_x * b_x;
      OP_AND:  res = a_x & b_x;
      OP_OR:   res = a_x | b_x;
      OP_NAND: res = {{D_WIDTH{1'b0}}, ~(a & b)};
      OP_NOR:  res = {{D_WIDTH{1'b0}}, ~(a | b)};
      OP_XOR:  res = a_x ^ b_x;
      OP_XNOR: res = {{D_WIDTH{1'b0}}, ~(a ^ b)};
      OP_EQ:   res = (a == b) ? W2'(1) : '0;
      OP_GT:   res = (a > b)  ? W2'(2) : '0;
      OP_LT:   res = (a < b)  ? W2'(3) : '0;
      OP_SHR:  res = a_x >> 1;
      OP_SHL:  res = a_x << 1;
`ifdef ALU_ITER_DIV_EN
      // Only reached for a zero divisor; nonzero divisors go to the iterative path.
      OP_DIV:  begin res = {a, {D_WIDTH{1'b1}}}; err = 1'b1; end
`endif
      default: begin res = '0; err = 1'b1; end
    endcase
    return {err, res};
  endfunction

  logic          w_accept;
  logic          w_div_start;
  logic          w_div_done;
  logic [W2-1:0] w_div_res;
  logic [W2:0]   w_alu;
  logic [W2-1:0] r_alu_out;
  logic          r_out_valid;
  logic          r_out_err;

`ifdef ALU_ITER_DIV_EN
  localparam int CNT_W = $clog2(D_WIDTH);
  typedef enum logic {S_IDLE = 1'b0, S_DIV = 1'b1} state_t;

  state_t             r_state, w_state_nxt;
  logic [D_WIDTH-1:0] r_quo, r_dvs, r_rem;
  logic [CNT_W-1:0]   r_cnt;
  logic [D_WIDTH:0]   w_shift, w_diff;
  logic [D_WIDTH-1:0] w_rem_nxt, w_quo_nxt;
  logic               w_div_last;

  assign w_div_start = w_accept && (ALU_FUN == OP_DIV) && (B != '0);
  // Restoring step: dividend bits shift MSB-first into the remainder, quotient bits fill r_quo.
  assign w_shift     = {r_rem, r_quo[D_WIDTH-1]};
  assign w_diff      = w_shift - {1'b0, r_dvs};
  assign w_rem_nxt   = w_diff[D_WIDTH] ? w_shift[D_WIDTH-1:0] : w_diff[D_WIDTH-1:0];
  assign w_quo_nxt   = {r_quo[D_WIDTH-2:0], ~w_diff[D_WIDTH]};
  assign w_div_last  = (r_cnt == CNT_W'(D_WIDTH - 1));
  assign w_div_done  = (r_state == S_DIV) && w_div_last;
  assign w_div_res   = {w_rem_nxt, w_quo_nxt};

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_div_start) w_state_nxt = S_DIV;
      S_DIV:  if (w_div_last)  w_state_nxt = S_IDLE;
    endcase
  end

  always_comb IN_READY = (r_state == S_IDLE);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_quo <= '0;
      r_dvs <= '0;
      r_rem <= '0;
      r_cnt <= '0;
    end else if (w_div_start) begin
      r_quo <= A;
      r_dvs <= B;
      r_rem <= '0;
      r_cnt <= '0;
    end else if (r_state == S_DIV) begin
      r_quo <= w_quo_nxt;
      r_rem <= w_rem_nxt;
      r_cnt <= w_div_last ? '0 : r_cnt + 1'b1;
    end
  end
`else
  assign IN_READY    = 1'b1;
  assign w_div_start = 1'b0;
  assign w_div_done  = 1'b0;
  assign w_div_res   = '0;
`endif

  assign w_accept = IN_VALID && IN_READY;
  assign w_alu    = f_alu(A, B, ALU_FUN);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_alu_out   <= '0;
      r_out_valid <= 1'b0;
      r_out_err   <= 1'b0;
    end else if (w_div_done) begin
      r_alu_out   <= w_div_res;
      r_out_err   <= 1'b0;
      r_out_valid <= 1'b1;
    end else if (w_accept && !w_div_start) begin
      r_alu_out   <= w_alu[W2-1:0];
      r_out_err   <= w_alu[W2];
      r_out_valid <= 1'b1;
    end else begin
      r_out_valid <= 1'b0;
    end
  end

  assign ALU_OUT   = r_alu_out;
  assign OUT_VALID = r_out_valid;
  assign OUT_ERR   = r_out_err;

endmodule

// File: tb/tb_alu_iter_hs.sv
// Self-checking bench for alu_iter_hs (W=8): directed vectors plus a cycle-level behavioural model.
`timescale 1ns/1ps
module tb_alu_iter_hs;
  localparam int W = 8;
`ifdef ALU_ITER_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  logic           CLK = 1'b0;
  logic           RST = 1'b1;
  logic [W-1:0]   A = '0;
  logic [W-1:0]   B = '0;
  logic [3:0]     ALU_FUN = '0;
  logic           IN_VALID = 1'b0;
  logic           IN_READY;
  logic           OUT_VALID;
  logic [2*W-1:0] ALU_OUT;
  logic           OUT_ERR;

  int nchk = 0;
  int nerr = 0;
  bit chk_en = 1'b0;

  alu_iter_hs #(.D_WIDTH(W), .FUN_WIDTH(4)) dut (
    .CLK(CLK), .RST(RST), .A(A), .B(B), .ALU_FUN(ALU_FUN), .IN_VALID(IN_VALID),
    .IN_READY(IN_READY), .OUT_VALID(OUT_VALID), .ALU_OUT(ALU_OUT), .OUT_ERR(OUT_ERR)
  );

  initial forever #5 CLK = ~CLK;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", nchk, nerr);
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h, need 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference arithmetic on plain integers: returns {err, result}.
  function automatic logic [16:0] model_op(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    int ia, ib, r;
    logic e;
    ia = int'(a); ib = int'(b); r = 0; e = 1'b0;
    case (op)
      4'h0: r = ia + ib;
      4'h1: r = ia - ib;
      4'h2: r = ia * ib;
      4'h3: begin e = 1'b1; r = DIV_EN ? ia * 256 + 255 : 0; end
      4'h4: r = ia & ib;
      4'h5: r = ia | ib;
      4'h6: r = 255 - (ia & ib);
      4'h7: r = 255 - (ia | ib);
      4'h8: r = ia ^ ib;
      4'h9: r = 255 - (ia ^ ib);
      4'hA: r = (ia == ib) ? 1 : 0;
      4'hB: r = (ia > ib) ? 2 : 0;
      4'hC: r = (ia < ib) ? 3 : 0;
      4'hD: r = ia / 2;
      4'hE: r = ia * 2;
      default: e = 1'b1;
    endcase
    return {e, 16'(r)};
  endfunction

  logic [15:0] m_out = '0;
  logic [15:0] m_pend = '0;
  logic        m_valid = 1'b0;
  logic        m_err = 1'b0;
  int          m_busy = 0;

  // Model: a divide with nonzero divisor occupies W cycles, everything else answers next cycle.
  always @(posedge CLK or negedge RST) begin
    if (!RST) begin
      m_out <= '0; m_valid <= 1'b0; m_err <= 1'b0; m_busy <= 0;
    end else if (m_busy > 0) begin
      m_busy <= m_busy - 1;
      if (m_busy == 1) begin
        m_out <= m_pend; m_err <= 1'b0; m_valid <= 1'b1;
      end else begin
        m_valid <= 1'b0;
      end
    end else if (IN_VALID) begin
      if (DIV_EN && ALU_FUN == 4'h3 && B != 0) begin
        m_pend  <= 16'((int'(A) % int'(B)) * 256 + int'(A) / int'(B));
        m_busy  <= W;
        m_valid <= 1'b0;
      end else begin
        {m_err, m_out} <= model_op(ALU_FUN, A, B);
        m_valid <= 1'b1;
      end
    end else begin
      m_valid <= 1'b0;
    end
  end

  always @(negedge CLK) begin
    if (chk_en) begin
      check("mdl_ready", 16'(IN_READY), 16'(m_busy == 0));
      check("mdl_valid", 16'(OUT_VALID), 16'(m_valid));
      check("mdl_out", ALU_OUT, m_out);
      check("mdl_err", 16'(OUT_ERR), 16'(m_err));
    end
  end

  task automatic put(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    ALU_FUN = op; A = a; B = b; IN_VALID = 1'b1;
  endtask

  task automatic step();
    @(posedge CLK); #1;
  endtask

  task automatic single(input string nm, input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                        input logic [15:0] exp, input logic experr);
    put(op, a, b);
    step();
    IN_VALID = 1'b0;
    @(negedge CLK);
    check({nm, "_out"}, ALU_OUT, exp);
    check({nm, "_err"}, 16'(OUT_ERR), 16'(experr));
    check({nm, "_vld"}, 16'(OUT_VALID), 16'd1);
  endtask

  initial begin
    int  nlow;
    bit  got;
    #2 RST = 1'b0;
    #1;
    check("rst_out", ALU_OUT, 16'h0000);
    check("rst_vld", 16'(OUT_VALID), 16'd0);
    check("rst_err", 16'(OUT_ERR), 16'd0);
    check("rst_rdy", 16'(IN_READY), 16'd1);
    chk_en = 1'b1;
    @(negedge CLK); #1 RST = 1'b1;

    // Back-to-back ADD then SUB.
    put(4'h0, 8'hFF, 8'h01);
    step();
    put(4'h1, 8'h03, 8'h05);
    @(negedge CLK);
    check("b2b_add", ALU_OUT, 16'h0100);
    check("b2b_vld1", 16'(OUT_VALID), 16'd1);
    step();
    IN_VALID = 1'b0;
    @(negedge CLK);
    check("b2b_sub", ALU_OUT, 16'hFFFE);
    check("b2b_vld2", 16'(OUT_VALID), 16'd1);
    check("b2b_err", 16'(OUT_ERR), 16'd0);
    @(negedge CLK);
    check("b2b_drop", 16'(OUT_VALID), 16'd0);
    check("b2b_hold", ALU_OUT, 16'hFFFE);

    single("mul", 4'h2, 8'hFF, 8'hFF, 16'hFE01, 1'b0);
    single("gt",  4'hB, 8'h80, 8'h7F, 16'h0002, 1'b0);
    single("shl", 4'hE, 8'h81, 8'h00, 16'h0102, 1'b0);
    single("shr", 4'hD, 8'h81, 8'h00, 16'h0040, 1'b0);
    single("nand", 4'h6, 8'hF0, 8'h3C, 16'h00CF, 1'b0);
    single("xnor", 4'h9, 8'hA5, 8'h0F, 16'h0055, 1'b0);
    single("eq",  4'hA, 8'h5A, 8'h5A, 16'h0001, 1'b0);
    single("lt",  4'hC, 8'h01, 8'h02, 16'h0003, 1'b0);
    single("ill", 4'hF, 8'h12, 8'h34, 16'h0000, 1'b1);
    single("div0", 4'h3, 8'h55, 8'h00, DIV_EN ? 16'h55FF : 16'h0000, 1'b1);

    // Asynchronous reset mid-stream.
    put(4'h0, 8'hFF, 8'h01);
    step();
    IN_VALID = 1'b0;
    check("ar_pre", ALU_OUT, 16'h0100);
    #1 RST = 1'b0;
    #1;
    check("ar_out", ALU_OUT, 16'h0000);
    check("ar_vld", 16'(OUT_VALID), 16'd0);
    check("ar_rdy", 16'(IN_READY), 16'd1);
    @(negedge CLK); #1 RST = 1'b1;

    // Divide 200/7 with a second request held on IN_VALID.
    put(4'h3, 8'd200, 8'd7);
    step();
    put(4'h0, 8'h10, 8'h03);
    nlow = 0; got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge CLK);
      if (OUT_VALID) got = 1'b1;
      else if (!IN_READY) nlow++;
    end
    check("div_seen", 16'(got), 16'd1);
    check("div_rdylow", 16'(nlow), DIV_EN ? 16'd8 : 16'd0);
    check("div_out", ALU_OUT, DIV_EN ? 16'h041C : 16'h0000);
    check("div_err", 16'(OUT_ERR), DIV_EN ? 16'd0 : 16'd1);
    step();
    IN_VALID = 1'b0;
    @(negedge CLK);
    check("held_add", ALU_OUT, 16'h0013);
    check("held_vld", 16'(OUT_VALID), 16'd1);

    // Reset during a divide aborts it.
    put(4'h3, 8'hFF, 8'h10);
    step();
    IN_VALID = 1'b0;
    repeat (4) @(posedge CLK);
    #2 RST = 1'b0;
    #1;
    check("abort_out", ALU_OUT, 16'h0000);
    check("abort_vld", 16'(OUT_VALID), 16'd0);
    check("abort_err", 16'(OUT_ERR), 16'd0);
    check("abort_rdy", 16'(IN_READY), 16'd1);
    repeat (2) @(negedge CLK);
    #1 RST = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      if (OUT_VALID) got = 1'b1;
    end
    check("abort_novld", 16'(got), 16'd0);
    single("post_add", 4'h0, 8'h01, 8'h01, 16'h0002, 1'b0);

    repeat (3) @(negedge CLK);
    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule

// File: doc/alu_iter_hs.md
Name: alu_iter_hs

Overview:
- Parametrised successor to the system's single-cycle 8-bit ALU.
- Adds a valid/ready input handshake, a registered error flag, full-width result rules and an iterative restoring divider. The divider takes D_WIDTH cycles and removes the combinational divide from the critical path.
- Sits between the register-file/control FSM and the result path in the ALU clock domain.

Parameters:
- D_WIDTH, 8, operand width in bits; must be 4 or more. ALU_OUT is 2*D_WIDTH bits.
- FUN_WIDTH, 4, opcode width; fixed encoding below, other values unsupported.

Ports:
- CLK  in  1  ALU domain clock.
- RST  in  1  asynchronous reset, active-low.
- A  in  D_WIDTH  operand A, unsigned.
- B  in  D_WIDTH  operand B, unsigned.
- ALU_FUN  in  FUN_WIDTH  opcode.
- IN_VALID  in  1  operands/opcode valid.
- IN_READY  out  1  block can accept; combinational from state only.
- OUT_VALID  out  1  registered one-cycle result strobe.
- ALU_OUT  out  2*D_WIDTH  registered result; holds last value between strobes.
- OUT_ERR  out  1  registered; qualified by OUT_VALID; held until next strobe.

Behaviour:
- Reset, async: ALU_OUT=0, OUT_VALID=0, OUT_ERR=0, state=IDLE, so IN_READY=1. Divider regs and count are cleared.
- A reset during DIV aborts the operation. No OUT_VALID is produced for the aborted operation.
- States:
  - IDLE: IN_READY=1.
  - DIV: IN_READY=0.
- Accept occurs at a rising edge when IN_VALID && IN_READY. Inputs are ignored when IN_READY=0.
- Single-cycle ops: accepted at edge N. The result and OUT_VALID=1 appear after edge N. OUT_VALID drops after edge N+1 unless another op is accepted there. Back-to-back accepts give an OUT_VALID strobe every cycle.
- Opcodes and result, zero-extended to 2W:
  - 0000 A+B, W+1 bits with carry.
  - 0001 A-B modulo 2^(2W); for example 3-5 gives all-ones minus 1.
  - 0010 A*B, full 2W bits.
  - 0011 A/B, iterative.
  - 0100 AND.
  - 0101 OR.
  - 0110 NAND, W bits.
  - 0111 NOR, W bits.
  - 1000 XOR.
  - 1001 XNOR, W bits.
  - 1010: 1 if A==B, else 0.
  - 1011: 2 if A>B, else 0.
  - 1100: 3 if A<B, else 0.
  - 1101 A>>1.
  - 1110 A<<1, W+1 bits.
  - 1111 illegal: ALU_OUT=0, OUT_ERR=1, OUT_VALID=1 after 1 cycle.
- OUT_ERR=0 for all legal ops with a valid result.
- Division, B!=0:
  - Accept edge 0 latches A and B, clears the remainder, count=0, state=DIV.
  - Each DIV edge performs one restoring step, MSB first.
  - At edge D_WIDTH the result is written to ALU_OUT and OUT_VALID=1, state returns to IDLE.
  - Result layout: ALU_OUT[W-1:0]=quotient, ALU_OUT[2W-1:W]=remainder.
  - Latency is D_WIDTH cycles. IN_READY is low from after edge 0 until after edge D_WIDTH.
  - A new op may be accepted in the first cycle IN_READY=1.
- Division, B==0: no DIV state. After 1 cycle: quotient = all ones, remainder = A, OUT_ERR=1.
- The count register wraps only by returning to IDLE; the count is never left nonzero in IDLE.
- IN_VALID held high during DIV is not captured. It is accepted once IN_READY returns high.

Optional Feature:
- Macro ALU_ITER_DIV_EN.
- Defined: divider and DIV state present as above.
- Undefined: no divider logic and IN_READY is tied to 1. Opcode 0011 behaves as illegal: ALU_OUT=0, OUT_ERR=1, OUT_VALID after 1 cycle.

Test Plan:
- W=8: reset low mid-stream -> ALU_OUT=0x0000, OUT_VALID=0, OUT_ERR=0, IN_READY=1 immediately, asynchronously.
- ADD A=0xFF B=0x01, then SUB A=0x03 B=0x05 back-to-back -> ALU_OUT=0x0100, then 0xFFFE on consecutive cycles, OUT_VALID high 2 cycles, OUT_ERR=0.
- MUL A=0xFF B=0xFF -> 0xFE01 next cycle. CMP 1011 A=0x80 B=0x7F -> 0x0002. SHL A=0x81 -> 0x0102.
- DIV A=200 B=7, IN_VALID held high with new operands -> IN_READY=0 for 8 cycles, OUT_VALID after edge 8 with ALU_OUT=0x041C. The held request is accepted on the next cycle.
- DIV A=0x55 B=0 -> after 1 cycle ALU_OUT=0x55FF, OUT_ERR=1. Opcode 1111 -> 0x0000, OUT_ERR=1.
- DIV A=0xFF B=0x10, RST asserted after edge 4 -> no OUT_VALID, outputs 0. After release, ADD 1+1 -> 0x0002. With macro undefined, DIV -> 0x0000, OUT_ERR=1, 1-cycle latency.
